pixel_batch_packer: RTL
=======================

// Module: pixel_batch_packer
// PURPOSE
//   Parametrised multi-channel successor to the per-colour batch buffers. Packs the DVI_RX pixel stream
//   (de/vs/hs plus COLOR_COUNT channels) into BATCH_SIZE-pixel batches and tags each with line/frame
//   markers and a valid-pixel count. Buffers up to FIFO_DEPTH batches behind a valid/ready handshake
//   feeding the SPI output stage; drops on overflow with a sticky flag.
// PARAMETERS
//   COLOR_COUNT  3  colour channels per pixel
//   COLOR_WIDTH  8  bits per channel
//   BATCH_SIZE   8  pixels per batch (>=2)
//   FIFO_DEPTH   4  batch entries buffered (power of 2, >=2)
//   MSB_FIRST    1  1: pixel 0 in the most significant slot of each channel slice; 0: least significant
// PORTS
//   clk                 in   1   pixel clock, single clock domain
//   rst                 in   1   synchronous, active-high reset
//   in_de               in   1   pixel valid (active video)
//   in_vs               in   1   vertical sync, active high
//   in_color            in   COLOR_COUNT*COLOR_WIDTH  channel c at [c*COLOR_WIDTH +: COLOR_WIDTH]
//   out_valid           out  1   FIFO head holds a batch
//   out_ready           in   1   consumer accepts head this cycle
//   out_batch           out  COLOR_COUNT*BATCH_SIZE*COLOR_WIDTH  channel c at [c*BATCH_SIZE*COLOR_WIDTH +: BATCH_SIZE*COLOR_WIDTH]
//   out_len             out  $clog2(BATCH_SIZE+1)  valid pixels in batch (1..BATCH_SIZE)
//   out_line_start      out  1   batch is first of its line
//   out_frame_start     out  1   batch is first of its frame
//   fill_level          out  $clog2(FIFO_DEPTH+1)  entries in FIFO
//   overflow            out  1   sticky: a batch was dropped
// BEHAVIOUR
//   - Reset: out_valid=0, out_batch=0, out_len=0, out_line_start=0, out_frame_start=0, fill_level=0,
//     overflow=0; pixel counter=0; FSM=WAIT_FRAME. Reset mid-batch discards partial data and FIFO contents.
//   - FSM: WAIT_FRAME -> (vs rising edge) BLANK -> (de=1) LINE -> (de falls) BLANK;
//     BLANK/LINE -> (vs rising edge) BLANK with frame_pending=1. Pixels in WAIT_FRAME are ignored.
//   - Edge detection uses in_vs/in_de registered one cycle; the pixel with de rising edge is the first pixel of the line.
//   - LINE: each de=1 cycle stores in_color into slot = pixel counter (mapped per MSB_FIRST); counter++.
//   - Counter reaches BATCH_SIZE (this pixel is last): push batch, out_len=BATCH_SIZE, counter=0 same edge.
//   - de falls with counter k>0: push partial batch, unused slots zero, out_len=k, counter=0.
//   - vs rising edge while counter>0 (malformed timing): partial batch discarded, no push.
//   - line_start tag set on first push after de rising edge; frame_start tag on first push after vs edge;
//     both cleared once attached. Both may be 1 on the same batch.
//   - Latency: batch pushed at edge N is visible at FIFO head (out_valid=1 if FIFO empty) after edge N.
//   - Handshake: pop on out_valid&&out_ready; out_* hold stable while out_valid&&!out_ready.
//   - Full: push with fill_level==FIFO_DEPTH and no pop same cycle -> batch dropped, overflow=1 until rst.
//     Push and pop same cycle when full -> both succeed, fill_level unchanged.
//   - Empty: out_ready ignored when out_valid=0; fill_level never underflows.
//   - Pointers wrap modulo FIFO_DEPTH; fill_level = writes - reads, updated same edge.
// TESTING
//   1 vs pulse, 16 px de burst, ch0=idx, ready=1 -> 2 batches, out_len=8; first frame_start=1,line_start=1; ch0 slice 0x0001..07 MSB-first.
//   2 Line of 11 px -> batch len 8, then len 3 with slots 3..7 = 0; only first batch has line_start=1.
//   3 ready=0, 5 full lines of 8 px -> fill_level=4, 5th dropped, overflow=1; stays 1 after drain until rst.
//   4 FIFO full, push and pop same cycle -> fill_level stays 4, overflow stays 0, popped order preserved.
//   5 Pixels before first vs -> no output; rst asserted mid-batch -> all outputs reset, WAIT_FRAME re-entered.
//   6 MSB_FIRST=0, BATCH_SIZE=4, COLOR_COUNT=1 -> pixel 0 in bits [7:0], out_len width 3.

Source files
------------

// File: rtl/pixel_batch_packer.sv
// Packs an active-video pixel stream into fixed-size multi-channel batches tagged with
// line/frame markers, buffered in a small FIFO behind a valid/ready handshake.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// WAIT_FRAME | after reset; pixels ignored until the first vs rising edge
// BLANK      | inside a frame, between lines; waits for a de rising edge
// LINE       | active video; pixels accumulate into the current batch
module pixel_batch_packer #(
   parameter int COLOR_COUNT = 3,
   parameter int COLOR_WIDTH = 8,
   parameter int BATCH_SIZE  = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter bit MSB_FIRST   = 1
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       in_de,
   input  logic                                       in_vs,
   input  logic [COLOR_COUNT*COLOR_WIDTH-1:0]         in_color,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic [COLOR_COUNT*BATCH_SIZE*COLOR_WIDTH-1:0] out_batch,
   output logic [$clog2(BATCH_SIZE+1)-1:0]            out_len,
   output logic                                       out_line_start,
   output logic                                       out_frame_start,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]            fill_level,
   output logic                                       overflow
);

   localparam int SW = BATCH_SIZE * COLOR_WIDTH;
   localparam int BW = COLOR_COUNT * SW;
   localparam int LW = $clog2(BATCH_SIZE + 1);
   localparam int FW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {WAIT_FRAME, BLANK, LINE} state_t;

   state_t          state, state_n;
   logic [LW-1:0]   cnt, cnt_n;
   logic [BW-1:0]   acc, acc_n, merged;
   logic            frame_pend, frame_pend_n, line_pend, line_pend_n;
   logic            vs_q, de_q, vs_rise, de_rise;
   logic            store, push, push_ls, push_fs;
   logic [BW-1:0]   push_batch;
   logic [LW-1:0]   push_len;
   int              slot;

   assign vs_rise = in_vs && !vs_q;
   assign de_rise = in_de && !de_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= WAIT_FRAME;
         cnt        <= '0;
         acc        <= '0;
         frame_pend <= 1'b0;
         line_pend  <= 1'b0;
         vs_q       <= 1'b0;
         de_q       <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         acc        <= acc_n;
         frame_pend <= frame_pend_n;
         line_pend  <= line_pend_n;
         vs_q       <= in_vs;
         de_q       <= in_de;
      end
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      acc_n        = acc;
      frame_pend_n = frame_pend;
      line_pend_n  = line_pend;
      store        = 1'b0;
      push         = 1'b0;
      push_batch   = acc;
      push_len     = cnt;
      push_ls      = 1'b0;
      push_fs      = 1'b0;

      // First pixel of a batch starts from a clean slate so short batches zero-fill.
      slot   = MSB_FIRST ? (BATCH_SIZE - 1 - int'(cnt)) : int'(cnt);
      merged = (cnt == '0) ? '0 : acc;
      for (int c = 0; c < COLOR_COUNT; c++)
         merged[c*SW + slot*COLOR_WIDTH +: COLOR_WIDTH] = in_color[c*COLOR_WIDTH +: COLOR_WIDTH];

      unique case (state)
         WAIT_FRAME: begin
            if (vs_rise) begin
               state_n      = BLANK;
               frame_pend_n = 1'b1;
               cnt_n        = '0;
            end
         end
         BLANK: begin
            if (vs_rise) begin
               frame_pend_n = 1'b1;
               cnt_n        = '0;
            end else if (de_rise) begin
               state_n     = LINE;
               line_pend_n = 1'b1;
               store       = 1'b1;
            end
         end
         LINE: begin
            if (vs_rise) begin
               state_n      = BLANK;
               frame_pend_n = 1'b1;
               cnt_n        = '0;
            end else if (in_de) begin
               store = 1'b1;
            end else begin
               state_n = BLANK;
               push    = (cnt != '0);
               cnt_n   = '0;
            end
         end
         default: state_n = WAIT_FRAME;
      endcase

      if (store) begin
         acc_n = merged;
         if (cnt == LW'(BATCH_SIZE - 1)) begin
            push       = 1'b1;
            push_batch = merged;
            push_len   = LW'(BATCH_SIZE);
            cnt_n      = '0;
         end else begin
            cnt_n = cnt + 1'b1;
         end
      end

      // Tags attach to whatever batch is pushed next, even if the FIFO drops it.
      if (push) begin
         push_ls      = line_pend_n;
         push_fs      = frame_pend_n;
         line_pend_n  = 1'b0;
         frame_pend_n = 1'b0;
      end
   end

   logic [BW-1:0] mem_batch [FIFO_DEPTH];
   logic [LW-1:0] mem_len   [FIFO_DEPTH];
   logic          mem_ls    [FIFO_DEPTH];
   logic          mem_fs    [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          pop, push_ok;

   assign pop     = out_valid && out_ready;
   assign push_ok = push && ((fill_level != FW'(FIFO_DEPTH)) || pop);

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_batch[wr_ptr] <= push_batch;
         mem_len[wr_ptr]   <= push_len;
         mem_ls[wr_ptr]    <= push_ls;
         mem_fs[wr_ptr]    <= push_fs;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (push && !push_ok) overflow <= 1'b1;
         case ({push_ok, pop})
            2'b10:   fill_level <= fill_level + 1'b1;
            2'b01:   fill_level <= fill_level - 1'b1;
            default: fill_level <= fill_level;
         endcase
      end
   end

   assign out_valid       = (fill_level != '0);
   assign out_batch       = out_valid ? mem_batch[rd_ptr] : '0;
   assign out_len         = out_valid ? mem_len[rd_ptr]   : '0;
   assign out_line_start  = out_valid && mem_ls[rd_ptr];
   assign out_frame_start = out_valid && mem_fs[rd_ptr];

endmodule
